voice_allocator: RTL

- Polyphony controller that sits between the note-event source (MIDI decoder or keyboard scanner) and a bank of VOICES envelope_generator instances.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice.
- Drives each voice's gate (the generator's trigger input) and note number.
- Inserts a forced gate-low gap on retrigger or steal, so the generator sees a fresh rising edge.

---
 rtl/voice_allocator.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note-on/note-off events onto envelope voices
// using LRU ranks, forcing a gate-low gap on retrigger or steal.
module voice_allocator #(
    parameter int VOICES     = 4,
    parameter int NOTE_WIDTH = 7,
    parameter int RETRIG_GAP = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         evt_valid,
    output logic                         evt_ready,
    input  logic                         evt_on,
    input  logic [NOTE_WIDTH-1:0]        evt_note,
    input  logic [VOICES-1:0]            voice_active,
    output logic [VOICES-1:0]            gate,
    output logic [VOICES*NOTE_WIDTH-1:0] voice_note,
    output logic                         stolen
);

    localparam int RW = $clog2(VOICES);
    localparam int GW = (RETRIG_GAP > 1) ? $clog2(RETRIG_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(RETRIG_GAP - 1);

    typedef enum logic [1:0] {IDLE, SELECT, GAP, APPLY} stateT;

    stateT                 state;
    logic                  evtReadyR;
    logic                  evtOnR;
    logic [NOTE_WIDTH-1:0] evtNoteR;
    logic                  hitR;
    logic                  stealR;
    logic                  stolenR;
    logic [VOICES-1:0]     gateR;
    logic [NOTE_WIDTH-1:0] noteR [VOICES];
    logic [RW-1:0]         rank  [VOICES];
    logic [RW-1:0]         target;
    logic [GW-1:0]         gapCnt;

    logic                  heldFound, relFound, freeFound, oldRelFound, oldHeldFound;
    logic [RW-1:0]         heldK, relK, freeK, oldRelK, oldHeldK;
    logic [RW-1:0]         oldRelRank, oldHeldRank;
    logic [RW-1:0]         selK;
    logic                  selHit;
    logic                  selSteal;

    // Candidate search for every priority class in one pass; the mux below picks the winner.
    always_comb begin
        heldFound    = 1'b0;
        heldK        = '0;
        relFound     = 1'b0;
        relK         = '0;
        freeFound    = 1'b0;
        freeK        = '0;
        oldRelFound  = 1'b0;
        oldRelK      = '0;
        oldRelRank   = '0;
        oldHeldFound = 1'b0;
        oldHeldK     = '0;
        oldHeldRank  = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            if (gateR[i]) begin
                if (!heldFound && noteR[i] == evtNoteR) begin
                    heldFound = 1'b1;
                    heldK     = i[RW-1:0];
                end
                if (!oldHeldFound || rank[i] > oldHeldRank) begin
                    oldHeldFound = 1'b1;
                    oldHeldK     = i[RW-1:0];
                    oldHeldRank  = rank[i];
                end
            end else begin
                if (!relFound && noteR[i] == evtNoteR) begin
                    relFound = 1'b1;
                    relK     = i[RW-1:0];
                end
                if (!freeFound && !voice_active[i]) begin
                    freeFound = 1'b1;
                    freeK     = i[RW-1:0];
                end
                if (!oldRelFound || rank[i] > oldRelRank) begin
                    oldRelFound = 1'b1;
                    oldRelK     = i[RW-1:0];
                    oldRelRank  = rank[i];
                end
            end
        end

        selK     = '0;
        selHit   = 1'b1;
        selSteal = 1'b0;
        if (!evtOnR) begin
            selK   = heldK;
            selHit = heldFound;
        end else if (heldFound) begin
            selK = heldK;
        end else if (relFound) begin
            selK = relK;
        end else if (freeFound) begin
            selK = freeK;
        end else if (oldRelFound) begin
            selK = oldRelK;
        end else begin
            selK     = oldHeldK;
            selSteal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            evtReadyR <= 1'b0;
            evtOnR    <= 1'b0;
            evtNoteR  <= '0;
            hitR      <= 1'b0;
            stealR    <= 1'b0;
            stolenR   <= 1'b0;
            gateR     <= '0;
            target    <= '0;
            gapCnt    <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                noteR[i] <= '0;
                rank[i]  <= i[RW-1:0];
            end
        end else begin
            stolenR <= 1'b0;
            case (state)
                IDLE: begin
                    if (evtReadyR && evt_valid) begin
                        evtOnR    <= evt_on;
                        evtNoteR  <= evt_note;
                        evtReadyR <= 1'b0;
                        state     <= SELECT;
                    end else begin
                        evtReadyR <= 1'b1;
                    end
                end
                SELECT: begin
                    target <= selK;
                    hitR   <= selHit;
                    stealR <= selSteal;
                    if (evtOnR && gateR[selK]) begin
                        gateR[selK] <= 1'b0;
                        gapCnt      <= '0;
                        state       <= GAP;
                    end else begin
                        state <= APPLY;
                    end
                end
                GAP: begin
                    if (gapCnt == GAP_LAST) begin
                        stolenR <= stealR;
                        state   <= APPLY;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                APPLY: begin
                    if (hitR) begin
                        gateR[target] <= evtOnR;
                        if (evtOnR) noteR[target] <= evtNoteR;
                        for (int unsigned i = 0; i < VOICES; i++) begin
                            if (rank[i] < rank[target]) rank[i] <= rank[i] + 1'b1;
                        end
                        rank[target] <= '0;
                    end
                    evtReadyR <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign evt_ready = evtReadyR;
    assign gate      = gateR;
    assign stolen    = stolenR;

    for (genvar v = 0; v < VOICES; v++) begin : g_note
        assign voice_note[v*NOTE_WIDTH +: NOTE_WIDTH] = noteR[v];
    end

endmodule
